// File: rtl/vector_serializer.sv
// -----------------------------------------------------------------------------
// vector_serializer
//   Takes a whole vector of up to BUF_SIZE words in one load handshake, then
//   plays the words out on a valid/ready stream, index 0 first. It feeds
//   descriptor and response vectors into the byte-wide TX path.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   loadData   vector; word i = loadData[i*DATA_WID +: DATA_WID]
//   loadLen    number of words to send (clamped to BUF_SIZE)
//   loadValid  load request
//   loadReady  block idle, a load is accepted this cycle if loadValid
//   dataOut    current word (0 while idle)
//   dataValid  dataOut is valid
//   dataReady  sink accepts dataOut this cycle
//   wordsLeft  words not yet handshaken
//   done       one-cycle pulse once the vector has been fully sent
//
// States
//   IDLE | waiting for a load; loadReady=1, dataValid=0, dataOut=0
//   SEND | presenting shadow word r_index; dataValid=1, loadReady=0
// -----------------------------------------------------------------------------
module vector_serializer #(
    parameter  int DATA_WID = 8,
    parameter  int BUF_SIZE = 8,
    localparam int LEN_WID  = $clog2(BUF_SIZE + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WID*BUF_SIZE-1:0] loadData,
    input  logic [LEN_WID-1:0]           loadLen,
    input  logic                         loadValid,
    output logic                         loadReady,
    output logic [DATA_WID-1:0]          dataOut,
    output logic                         dataValid,
    input  logic                         dataReady,
    output logic [LEN_WID-1:0]           wordsLeft,
    output logic                         done
);

    localparam logic [LEN_WID-1:0] LP_BUF_LEN = LEN_WID'(BUF_SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [DATA_WID*BUF_SIZE-1:0] r_shadow;
    logic [LEN_WID-1:0]           r_len;
    logic [LEN_WID-1:0]           r_index;
    logic                         r_done;

    logic                         w_accept;
    logic                         w_handshake;
    logic                         w_last;
    logic [LEN_WID-1:0]           w_len_clamped;

    always_comb begin
        w_state_next  = r_state;
        loadReady     = 1'b0;
        dataValid     = 1'b0;
        dataOut       = '0;
        wordsLeft     = '0;
        w_accept      = 1'b0;
        w_handshake   = 1'b0;
        w_last        = (r_index == (r_len - LEN_WID'(1)));
        w_len_clamped = (loadLen > LP_BUF_LEN) ? LP_BUF_LEN : loadLen;

        case (r_state)
            IDLE: begin
                loadReady = 1'b1;
                w_accept  = loadValid;
                // A zero-length vector never enters SEND; it only produces done.
                if (loadValid && (w_len_clamped != '0)) begin
                    w_state_next = SEND;
                end
            end
            SEND: begin
                dataValid   = 1'b1;
                dataOut     = r_shadow[int'(r_index) * DATA_WID +: DATA_WID];
                wordsLeft   = r_len - r_index;
                w_handshake = dataReady;
                if (dataReady && w_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        done = r_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shadow <= '0;
            r_len    <= '0;
            r_index  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_accept && (w_len_clamped == '0)) || (w_handshake && w_last);
            if (w_accept) begin
                r_shadow <= loadData;
                r_len    <= w_len_clamped;
                r_index  <= '0;
            end else if (w_handshake) begin
                r_index <= w_last ? '0 : r_index + LEN_WID'(1);
            end
        end
    end

endmodule

// File: tb/tb_vector_serializer.sv
module tb_vector_serializer;

    localparam int DATA_WID = 8;
    localparam int BUF_SIZE = 8;
    localparam int LEN_WID  = $clog2(BUF_SIZE + 1);

    logic                         clk;
    logic                         rst;
    logic [DATA_WID*BUF_SIZE-1:0] loadData;
    logic [LEN_WID-1:0]           loadLen;
    logic                         loadValid;
    logic                         loadReady;
    logic [DATA_WID-1:0]          dataOut;
    logic                         dataValid;
    logic                         dataReady;
    logic [LEN_WID-1:0]           wordsLeft;
    logic                         done;

    vector_serializer #(.DATA_WID(DATA_WID), .BUF_SIZE(BUF_SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .loadData (loadData),
        .loadLen  (loadLen),
        .loadValid(loadValid),
        .loadReady(loadReady),
        .dataOut  (dataOut),
        .dataValid(dataValid),
        .dataReady(dataReady),
        .wordsLeft(wordsLeft),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the outstanding words of the current vector as a queue.
    logic [DATA_WID-1:0] m_q[$];
    logic                m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_done = 1'b0;
        end else begin
            logic nd;
            int   n;
            nd = 1'b0;
            if (m_q.size() > 0) begin
                if (dataReady) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) nd = 1'b1;
                end
            end else if (loadValid) begin
                n = (int'(loadLen) > BUF_SIZE) ? BUF_SIZE : int'(loadLen);
                for (int i = 0; i < n; i++) m_q.push_back(loadData[i*DATA_WID +: DATA_WID]);
                if (n == 0) nd = 1'b1;
            end
            m_done = nd;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("dataValid", 32'(dataValid), 32'(m_q.size() > 0));
        chk("dataOut",   32'(dataOut),   (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        chk("wordsLeft", 32'(wordsLeft), 32'(m_q.size()));
        chk("loadReady", 32'(loadReady), 32'(m_q.size() == 0));
        chk("done",      32'(done),      32'(m_done));
    end

    // Event log sampled at each rising edge (values seen before the edge).
    int                  cyc = 0;
    logic [DATA_WID-1:0] hs_log[$];
    int                  acc_q[$];
    int                  done_q[$];

    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (loadValid && loadReady) acc_q.push_back(cyc);
            if (dataValid && dataReady) hs_log.push_back(dataOut);
            if (done) done_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        hs_log.delete();
        acc_q.delete();
        done_q.delete();
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic do_load(input logic [DATA_WID*BUF_SIZE-1:0] d, input int len);
        logic ok;
        ok        = 1'b0;
        loadData  = d;
        loadLen   = LEN_WID'(len);
        loadValid = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (loadReady) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("load_accept_timeout", 32'(ok), 32'd1);
        @(negedge clk);
        loadValid = 1'b0;
        loadData  = ~d;
    endtask

    task automatic wait_idle(input logic rnd);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (loadReady) begin
                ok = 1'b1;
                break;
            end
            if (rnd) dataReady = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("idle_timeout", 32'(ok), 32'd1);
        dataReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    logic [DATA_WID*BUF_SIZE-1:0] vec_desc;
    logic [DATA_WID*BUF_SIZE-1:0] vec_abc;
    logic [DATA_WID*BUF_SIZE-1:0] vec_a;
    logic [DATA_WID*BUF_SIZE-1:0] vec_b;

    initial begin
        rst       = 1'b1;
        loadData  = '0;
        loadLen   = '0;
        loadValid = 1'b0;
        dataReady = 1'b1;
        for (int i = 0; i < BUF_SIZE; i++) vec_desc[i*8 +: 8] = 8'(7 - i);
        vec_abc = {8'hF2, 8'hF1, 8'hF0, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        vec_a   = {48'h0, 8'h22, 8'h11};
        vec_b   = {48'h0, 8'h44, 8'h33};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_loadReady", 32'(loadReady), 32'd1);
        chk("idle_dataOut",   32'(dataOut),   32'd0);

        // Full vector, sink always ready.
        clear_logs();
        do_load(vec_desc, 8);
        wait_idle(1'b0);
        chk("t2_count", 32'(hs_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < hs_log.size(); i++) chk("t2_word", 32'(hs_log[i]), 32'(7 - i));
        chk("t2_done_count", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0 && acc_q.size() > 0)
            chk("t2_done_latency", 32'(done_q[0] - acc_q[0]), 32'd9);

        // Same vector, random backpressure.
        clear_logs();
        do_load(vec_desc, 8);
        wait_idle(1'b1);
        chk("t3_count", 32'(hs_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < hs_log.size(); i++) chk("t3_word", 32'(hs_log[i]), 32'(7 - i));
        chk("t3_done_count", 32'(done_q.size()), 32'd1);

        // Partial vector.
        clear_logs();
        do_load(vec_abc, 3);
        wait_idle(1'b0);
        chk("t4_count", 32'(hs_log.size()), 32'd3);
        if (hs_log.size() == 3) begin
            chk("t4_w0", 32'(hs_log[0]), 32'hAA);
            chk("t4_w1", 32'(hs_log[1]), 32'hBB);
            chk("t4_w2", 32'(hs_log[2]), 32'hCC);
        end
        if (done_q.size() > 0 && acc_q.size() > 0)
            chk("t4_done_latency", 32'(done_q[0] - acc_q[0]), 32'd4);

        // Zero length, then over-length clamp.
        clear_logs();
        do_load(vec_abc, 0);
        wait_idle(1'b0);
        chk("t5_zero_count", 32'(hs_log.size()), 32'd0);
        chk("t5_zero_done",  32'(done_q.size()), 32'd1);
        if (done_q.size() > 0 && acc_q.size() > 0)
            chk("t5_zero_latency", 32'(done_q[0] - acc_q[0]), 32'd1);
        clear_logs();
        do_load(vec_abc, 15);
        wait_idle(1'b0);
        chk("t5_clamp_count", 32'(hs_log.size()), 32'd8);
        if (hs_log.size() == 8) chk("t5_clamp_last", 32'(hs_log[7]), 32'hF2);

        // Reset mid-vector, with a simultaneous load request that must lose.
        clear_logs();
        do_load(vec_desc, 8);
        for (int k = 0; k < 20 && hs_log.size() < 2; k++) @(negedge clk);
        chk("t6_pre_count", 32'(hs_log.size()), 32'd2);
        rst       = 1'b1;
        loadValid = 1'b1;
        loadData  = vec_abc;
        loadLen   = LEN_WID'(3);
        @(negedge clk);
        rst       = 1'b0;
        loadValid = 1'b0;
        chk("t6_rst_dataValid", 32'(dataValid), 32'd0);
        chk("t6_rst_loadReady", 32'(loadReady), 32'd1);
        chk("t6_rst_wordsLeft", 32'(wordsLeft), 32'd0);
        chk("t6_rst_done",      32'(done),      32'd0);
        repeat (3) @(negedge clk);
        chk("t6_no_done", 32'(done_q.size()), 32'd0);
        clear_logs();
        do_load(vec_desc, 8);
        wait_idle(1'b0);
        chk("t6_fresh_count", 32'(hs_log.size()), 32'd8);
        if (hs_log.size() > 0) chk("t6_fresh_first", 32'(hs_log[0]), 32'h07);

        // Back-to-back: second load held during SEND, accepted in the done cycle.
        clear_logs();
        do_load(vec_a, 2);
        do_load(vec_b, 2);
        wait_idle(1'b0);
        chk("t6_b2b_count", 32'(hs_log.size()), 32'd4);
        if (hs_log.size() == 4) begin
            chk("t6_b2b_w0", 32'(hs_log[0]), 32'h11);
            chk("t6_b2b_w1", 32'(hs_log[1]), 32'h22);
            chk("t6_b2b_w2", 32'(hs_log[2]), 32'h33);
            chk("t6_b2b_w3", 32'(hs_log[3]), 32'h44);
        end
        chk("t6_b2b_dones", 32'(done_q.size()), 32'd2);
        if (done_q.size() > 0 && acc_q.size() > 1)
            chk("t6_b2b_bubble", 32'(acc_q[1] - done_q[0]), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
